// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg: shared state encoding and bus widths for the MMIO bus arbiter
package mmio_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, LOCKED} arb_state_t;
  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;
  localparam int MAX_MASTERS = 8;
endpackage

// File: rtl/mmio_rr_picker.sv
// mmio_rr_picker: combinational round-robin winner select (rotate by pointer, then priority-encode)
module mmio_rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);
  logic [N-1:0] rot;
  int off;
  // rotate so the pointer's master sits at bit 0, take the lowest set bit, undo the rotation
  always_comb begin
    rot = '0;
    off = 0;
    for (int i = 0; i < N; i++) rot[i] = req[(i + int'(ptr)) % N];
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
    winner = PW'((off + int'(ptr)) % N);
    valid = |req;
  end
endmodule

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: round-robin sharing of one MMIO port between masters; ARB_LOCK_EN adds bus locking
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = MMIO_ADDR_W,
  parameter int DATA_W      = MMIO_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_wr,
  input  logic [NUM_MASTERS-1:0] m_rd,
  input  logic [ADDR_W-1:0]      m_addr    [NUM_MASTERS],
  input  logic [DATA_W-1:0]      m_wr_data [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] m_lock,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [DATA_W-1:0]      m_rd_data,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [ADDR_W-1:0]      mmio_addr,
  output logic [DATA_W-1:0]      mmio_wr_data,
  input  logic [DATA_W-1:0]      mmio_rd_data,
  output logic                   busy
);
  localparam int PW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  arb_state_t state, state_nxt;
  logic [PW-1:0] ptr, owner, winner, sel;
  logic valid, grant;
  mmio_rr_picker #(.N(NUM_MASTERS), .PW(PW)) picker (
    .req(m_req),
    .ptr(ptr),
    .winner(winner),
    .valid(valid)
  );
  assign busy = state != IDLE;
`ifndef ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^m_lock;
`endif
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // next state and grant decision; a locked bus only listens to its owner
  always_comb begin
    state_nxt = state;
    grant = 1'b0;
    sel = winner;
    case (state)
      IDLE: begin
        grant = valid;
        state_nxt = valid ? ACCESS : IDLE;
      end
      ACCESS: state_nxt = ACK;
`ifdef ARB_LOCK_EN
      ACK: state_nxt = m_lock[owner] ? LOCKED : IDLE;
      LOCKED: begin
        grant = m_req[owner];
        sel = owner;
        state_nxt = m_req[owner] ? ACCESS : (m_lock[owner] ? LOCKED : IDLE);
      end
`else
      ACK: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  // command latch into registered bus outputs, read capture and ack pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      owner <= '0;
      m_ack <= '0;
      m_rd_data <= '0;
      mmio_cs <= 1'b0;
      mmio_wr <= 1'b0;
      mmio_rd <= 1'b0;
      mmio_addr <= '0;
      mmio_wr_data <= '0;
    end else begin
      m_ack <= '0;
      if (grant) begin
        owner <= sel;
        mmio_cs <= 1'b1;
        mmio_wr <= m_wr[sel];
        mmio_rd <= m_rd[sel] & ~m_wr[sel];
        mmio_addr <= m_addr[sel];
        mmio_wr_data <= m_wr_data[sel];
        if (state == IDLE) ptr <= (sel == PW'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
      end
      if (state == ACCESS) begin
        m_ack[owner] <= 1'b1;
        if (mmio_rd) m_rd_data <= mmio_rd_data;
        mmio_cs <= 1'b0;
        mmio_wr <= 1'b0;
        mmio_rd <= 1'b0;
        mmio_addr <= '0;
        mmio_wr_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb_mmio_bus_arbiter: directed scoreboard bench for the MMIO bus arbiter with four masters
module tb_mmio_bus_arbiter;
  localparam int NM = 4;
  typedef struct {int m; logic [20:0] addr; logic wr; logic rd; logic [31:0] wd;} bus_t;
  typedef struct {int m; logic [31:0] rd;} ack_t;
  logic clk, reset;
  logic [NM-1:0] m_req, m_wr, m_rd, m_lock, m_ack;
  logic [20:0] m_addr [NM];
  logic [31:0] m_wr_data [NM];
  logic [31:0] m_rd_data, mmio_wr_data, mmio_rd_data;
  logic mmio_cs, mmio_wr, mmio_rd, busy;
  logic [20:0] mmio_addr;
  bus_t bus_q[$];
  ack_t ack_q[$];
  int passed = 0, total = 0, cyc = 0, last_cs = -100;
  logic hold = 1'b0, chk_gap = 1'b0;
  logic [31:0] last_rd = '0;

  mmio_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(21), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_rd(m_rd),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_lock(m_lock), .m_ack(m_ack),
    .m_rd_data(m_rd_data), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .busy(busy)
  );

  function automatic logic [31:0] rd_fn(input logic [20:0] a);
    return (a == 21'h43) ? 32'hDEADBEEF : {11'h155, a};
  endfunction
  assign mmio_rd_data = rd_fn(mmio_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_master(input int m, input logic wr, input logic rd, input logic [20:0] a, input logic [31:0] wd);
    m_wr[m] = wr;
    m_rd[m] = rd;
    m_addr[m] = a;
    m_wr_data[m] = wd;
    m_req[m] = 1'b1;
  endtask

  task automatic exp_grant(input int m);
    bus_t b;
    ack_t k;
    b.m = m;
    b.addr = m_addr[m];
    b.wr = m_wr[m];
    b.rd = m_rd[m] & ~m_wr[m];
    b.wd = m_wr_data[m];
    if (b.rd) last_rd = rd_fn(b.addr);
    k.m = m;
    k.rd = last_rd;
    bus_q.push_back(b);
    ack_q.push_back(k);
  endtask

  task automatic cycle();
    bus_t b;
    ack_t k;
    @(posedge clk);
    #1;
    cyc++;
    if (mmio_cs) begin
      if (bus_q.size() == 0) chk("bus_unexpected", 64'(mmio_addr), 64'h1FFFFF);
      else begin
        b = bus_q.pop_front();
        chk("bus_addr", 64'(mmio_addr), 64'(b.addr));
        chk("bus_wr", 64'(mmio_wr), 64'(b.wr));
        chk("bus_rd", 64'(mmio_rd), 64'(b.rd));
        chk("bus_wd", 64'(mmio_wr_data), 64'(b.wd));
      end
      if (chk_gap && last_cs >= 0) chk("bus_gap", 64'(cyc - last_cs), 64'd3);
      last_cs = cyc;
    end else chk("bus_idle", 64'({mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}), 64'd0);
    if (m_ack != '0) begin
      if (ack_q.size() == 0) chk("ack_unexpected", 64'(m_ack), 64'd0);
      else begin
        k = ack_q.pop_front();
        chk("ack_owner", 64'(m_ack), 64'(NM'(1) << k.m));
        chk("ack_rd_data", 64'(m_rd_data), 64'(k.rd));
        if (!hold) m_req[k.m] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((bus_q.size() != 0 || ack_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", 64'(bus_q.size() + ack_q.size()), 64'd0);
    bus_q.delete();
    ack_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_req = '0;
    m_wr = '0;
    m_rd = '0;
    m_lock = '0;
    for (int i = 0; i < NM; i++) begin
      m_addr[i] = '0;
      m_wr_data[i] = '0;
    end
    cycle();
    cycle();
    reset = 1'b0;
    hold = 1'b0;
    last_rd = '0;
    bus_q.delete();
    ack_q.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_rd_data", 64'(m_rd_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cs", 64'(mmio_cs), 64'd0);
    set_master(0, 1'b0, 1'b1, 21'h00043, 32'h0);
    exp_grant(0);
    cycle();
    chk("lat_cs", 64'(mmio_cs), 64'd1);
    chk("lat_busy", 64'(busy), 64'd1);
    cycle();
    chk("lat_ack", 64'(m_ack), 64'd1);
    drain(10);
    cycle();
    cycle();
    chk("rd_hold", 64'(m_rd_data), 64'hDEADBEEF);
    chk("idle_busy", 64'(busy), 64'd0);
    do_reset();
    chk_gap = 1'b1;
    last_cs = -100;
    set_master(0, 1'b0, 1'b1, 21'h00010, 32'h0);
    set_master(1, 1'b0, 1'b1, 21'h00020, 32'h0);
    exp_grant(0);
    exp_grant(1);
    drain(20);
    chk_gap = 1'b0;
    set_master(0, 1'b0, 1'b1, 21'h00011, 32'h0);
    exp_grant(0);
    drain(10);
    cycle();
    chk_gap = 1'b1;
    last_cs = -100;
    set_master(0, 1'b0, 1'b1, 21'h00012, 32'h0);
    set_master(1, 1'b0, 1'b1, 21'h00022, 32'h0);
    exp_grant(1);
    exp_grant(0);
    drain(20);
    chk_gap = 1'b0;
    cycle();
    set_master(1, 1'b1, 1'b1, 21'h00055, 32'h12345678);
    exp_grant(1);
    drain(10);
    chk("wr_keeps_rd_data", 64'(m_rd_data), 64'(rd_fn(21'h00012)));
    set_master(2, 1'b0, 1'b0, 21'h00066, 32'hCAFEF00D);
    exp_grant(2);
    drain(10);
    cycle();
    set_master(1, 1'b0, 1'b1, 21'h00077, 32'h0);
    exp_grant(1);
    cycle();
    chk("midop_cs", 64'(mmio_cs), 64'd1);
    reset = 1'b1;
    m_req = '0;
    ack_q.delete();
    last_rd = '0;
    cycle();
    chk("midop_ack", 64'(m_ack), 64'd0);
    chk("midop_cs_off", 64'(mmio_cs), 64'd0);
    chk("midop_busy", 64'(busy), 64'd0);
    chk("midop_rd_data", 64'(m_rd_data), 64'd0);
    reset = 1'b0;
    cycle();
    chk("midop_no_ack", 64'(m_ack), 64'd0);
    set_master(0, 1'b1, 1'b0, 21'h00031, 32'h00000031);
    set_master(2, 1'b1, 1'b0, 21'h00032, 32'h00000032);
    exp_grant(0);
    exp_grant(2);
    drain(20);
    do_reset();
    hold = 1'b1;
    chk_gap = 1'b1;
    last_cs = -100;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 1'b0, 21'(32'h100 + i), 32'(i));
    for (int i = 0; i <= NM; i++) exp_grant(i % NM);
    drain(40);
    chk_gap = 1'b0;
    do_reset();
    m_lock[0] = 1'b1;
    set_master(0, 1'b1, 1'b0, 21'h00200, 32'hA0);
    set_master(1, 1'b1, 1'b0, 21'h00300, 32'hB0);
    exp_grant(0);
`ifdef ARB_LOCK_EN
    drain(10);
    set_master(0, 1'b1, 1'b0, 21'h00201, 32'hA1);
    exp_grant(0);
    drain(10);
    set_master(0, 1'b1, 1'b0, 21'h00202, 32'hA2);
    exp_grant(0);
    drain(10);
    cycle();
    cycle();
    chk("lock_starve", 64'(mmio_cs), 64'd0);
    chk("lock_busy", 64'(busy), 64'd1);
    m_lock[0] = 1'b0;
    exp_grant(1);
    drain(10);
`else
    exp_grant(1);
    drain(20);
`endif
    cycle();
    chk("end_idle", 64'(busy), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
Shares the single MMIO bus port (cs/wr/rd/addr/wr_data/rd_data into the MMIO slot controller) between NUM_MASTERS bus masters, e.g. CPU and DMA.
- Round-robin arbitration, one transaction per grant.
- Req/ack handshake per master; read data is registered and returned with ack.
- Sits between the masters' bus bridges and the MMIO controller.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 21, MMIO address width
DATA_W, 32, MMIO data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_req  in  NUM_MASTERS  per-master request; held until ack
m_wr  in  NUM_MASTERS  per-master write strobe (qualifies req)
m_rd  in  NUM_MASTERS  per-master read strobe (qualifies req)
m_addr  in  ADDR_W x NUM_MASTERS (unpacked array)  per-master address
m_wr_data  in  DATA_W x NUM_MASTERS (unpacked array)  per-master write data
m_lock  in  NUM_MASTERS  bus-lock request (used only with ARB_LOCK_EN)
m_ack  out  NUM_MASTERS  one-cycle completion pulse to the owner
m_rd_data  out  DATA_W  captured read data; valid while m_ack is high
mmio_cs  out  1  MMIO chip select
mmio_wr  out  1  MMIO write
mmio_rd  out  1  MMIO read
mmio_addr  out  ADDR_W  MMIO address
mmio_wr_data  out  DATA_W  MMIO write data
mmio_rd_data  in  DATA_W  MMIO read data (combinational from slots)
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset:
  - State IDLE, rr pointer = 0, owner = 0.
  - All outputs 0: m_ack, m_rd_data, all mmio_* outputs, busy.
  - Reset mid-transaction aborts it with no ack; the master must re-request.
- FSM states: IDLE, ACCESS, ACK (plus LOCKED with the feature).
- IDLE:
  - If any m_req is high, pick a winner by round-robin starting at the pointer.
  - Register owner = winner and latch its wr, rd, addr and wr_data.
  - Go to ACCESS; pointer <= (winner+1) mod NUM_MASTERS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mmio_cs=1; mmio_wr/mmio_rd/mmio_addr/mmio_wr_data driven from the latched command (registered outputs).
  - At the end of the cycle, capture mmio_rd_data into m_rd_data if it is a read; go to ACK.
- ACK (1 cycle):
  - m_ack[owner]=1; all mmio_* outputs return to 0.
  - Next state IDLE.
- Latency: req sampled at edge N → mmio_cs high in cycle N+1 → m_ack high in cycle N+2. Throughput is one transaction per 3 cycles.
- Master rules:
  - The master must drop m_req at the edge ending its ack cycle, or raise a new req later.
  - A req held past ack is treated as a new request, at the lowest rr priority.
- m_wr and m_rd both high: write wins; mmio_rd is forced to 0.
- m_req high with neither strobe set: a bus cycle is still issued (cs only) and ack is returned.
- m_rd_data holds its value after ack until the next read capture. Writes do not modify it.
- Request inputs are ignored outside IDLE/LOCKED. Changes on a non-owner's inputs have no effect.
- Pointer wrap: winner NUM_MASTERS-1 → pointer 0.

Optional Feature:
ARB_LOCK_EN:
- Defined:
  - In ACK, if m_lock[owner]=1, go to LOCKED instead of IDLE.
  - LOCKED: only the owner's m_req is considered. On owner req, latch its command and go to ACCESS; the pointer does not move.
  - Owner m_lock=0 with no owner req: go to IDLE.
  - Other masters starve while the bus is locked.
- Undefined: m_lock is ignored and the LOCKED state does not exist.

Decomposition:
- Package mmio_arb_pkg holds:
  - state enum arb_state_t {IDLE, ACCESS, ACK, LOCKED}
  - MMIO_ADDR_W=21, MMIO_DATA_W=32
  - max-masters constant
- Sub-module mmio_rr_picker (purely combinational):
  - Inputs: request vector, pointer.
  - Outputs: winner index, valid.
  - Rotate, then priority-encode.

Test Plan:
- Single read: M0 req rd, addr=0x00043 while mmio_rd_data=0xDEADBEEF → mmio_cs/rd high 1 cycle with addr 0x00043; m_ack[0] pulses 2 cycles after req; m_rd_data=0xDEADBEEF.
- Contention: M0 and M1 req together from reset → M0 served first, then M1 (pointer=1); a repeated pair → M1 first, then M0. No gaps other than the IDLE cycle.
- Write/read precedence: M1 m_wr=m_rd=1, wr_data=0x12345678 → mmio_wr=1, mmio_rd=0, mmio_wr_data=0x12345678; m_rd_data unchanged.
- Reset mid-op: assert reset during ACCESS → next cycle all outputs 0, no m_ack, pointer 0; after release, a new req completes normally.
- Wrap, NUM_MASTERS=4: all reqs held continuously → grant order 0,1,2,3,0.
- ARB_LOCK_EN: M0 with lock=1 does 3 back-to-back writes while M1 requests → M1 gets no grant until M0 drops lock; then M1 is acked.
